// File: rtl/pwm_compare_amisha_pkg.sv
// Shared definitions for the PWM compare block: FSM state encoding and
// the compare-range helpers used by the top level.
package pwm_pkg_amisha;

  // Handshake FSM: IDLE accepts a new compare value, PEND holds it until
  // the next counter period boundary.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PEND = 1'b1
  } pwm_state_e;

  // Default counter width and the matching full-scale compare value.
  localparam int N_DEFAULT = 8;
  localparam int CMP_MAX   = 2 ** N_DEFAULT;

  // Full-scale compare value (2^n) for an n-bit counter.
  function automatic int cmp_max_f(input int n);
    return 32'sd1 <<< n;
  endfunction

endpackage

// File: rtl/pwm_compare_amisha_deadtime.sv
// Dead-time generator: turns the registered PWM into a complementary pair
// with DEADTIME_amisha cycles where both outputs are low after every edge.
// Instantiated only when PWM_COMPL_EN is defined.
module deadtime_gen_amisha #(
  parameter int DEADTIME_amisha = 2
) (
  input  logic clk_amisha,
  input  logic reset_n_amisha,
  input  logic pwm_raw_amisha,
  output logic pwm_amisha,
  output logic pwm_n_amisha
);

  localparam logic [3:0] DT_L = 4'(DEADTIME_amisha);

  logic       pwm_prev_r;
  logic [3:0] dt_cnt_r;
  logic       pwm_r;
  logic       pwm_n_r;

  logic [3:0] dt_cnt_next_s;
  logic       pwm_next_s;
  logic       pwm_n_next_s;

  // Next-state logic: a raw edge (even inside dead time) reloads the counter
  // and forces both outputs low; outputs follow only once the counter is 0.
  always_comb begin
    dt_cnt_next_s = dt_cnt_r;
    pwm_next_s    = 1'b0;
    pwm_n_next_s  = 1'b0;
    if (pwm_raw_amisha != pwm_prev_r) begin
      if (DT_L == 4'd0) begin
        dt_cnt_next_s = 4'd0;
        pwm_next_s    = pwm_raw_amisha;
        pwm_n_next_s  = ~pwm_raw_amisha;
      end else begin
        dt_cnt_next_s = DT_L - 4'd1;
        pwm_next_s    = 1'b0;
        pwm_n_next_s  = 1'b0;
      end
    end else if (dt_cnt_r != 4'd0) begin
      dt_cnt_next_s = dt_cnt_r - 4'd1;
      pwm_next_s    = 1'b0;
      pwm_n_next_s  = 1'b0;
    end else begin
      dt_cnt_next_s = 4'd0;
      pwm_next_s    = pwm_raw_amisha;
      pwm_n_next_s  = ~pwm_raw_amisha;
    end
  end

  // Dead-time state and registered complementary outputs.
  always_ff @(posedge clk_amisha) begin
    if (!reset_n_amisha) begin
      pwm_prev_r <= 1'b0;
      dt_cnt_r   <= 4'd0;
      pwm_r      <= 1'b0;
      pwm_n_r    <= 1'b0;
    end else begin
      pwm_prev_r <= pwm_raw_amisha;
      dt_cnt_r   <= dt_cnt_next_s;
      pwm_r      <= pwm_next_s;
      pwm_n_r    <= pwm_n_next_s;
    end
  end

  assign pwm_amisha   = pwm_r;
  assign pwm_n_amisha = pwm_n_r;

endmodule

// File: rtl/pwm_compare_amisha.sv
// PWM compare stage fed by the universal binary counter. A double-buffered
// compare register (shadow loaded over valid/ready, active swapped only on a
// counter period boundary) drives a registered PWM and a period-boundary pulse.
// Optional feature macro: PWM_COMPL_EN adds pwm_n_amisha with dead time.
module pwm_compare_amisha
  import pwm_pkg_amisha::*;
#(
  parameter int N_amisha        = 8,
  parameter int DEADTIME_amisha = 2
) (
  input  logic                clk_amisha,
  input  logic                reset_n_amisha,
  input  logic [N_amisha-1:0] q_amisha,
  input  logic                max_tick_amisha,
  input  logic                min_tick_amisha,
  input  logic                cnt_en_amisha,
  input  logic                cnt_up_amisha,
  input  logic                cnt_clr_amisha,
  input  logic                cmp_valid_amisha,
  input  logic [N_amisha:0]   cmp_data_amisha,
  output logic                cmp_ready_amisha,
  output logic                pwm_amisha,
`ifdef PWM_COMPL_EN
  output logic                pwm_n_amisha,
`endif
  output logic                period_tick_amisha
);

  localparam logic [N_amisha:0] CMP_MAX_L = (N_amisha + 1)'(cmp_max_f(N_amisha));

  // Values above full scale behave exactly like full scale, so store 2^N.
  function automatic logic [N_amisha:0] clamp_cmp(input logic [N_amisha:0] d);
    if (d > CMP_MAX_L) begin
      return CMP_MAX_L;
    end else begin
      return d;
    end
  endfunction

  pwm_state_e          state_r;
  pwm_state_e          state_next_s;
  logic [N_amisha:0]   cmp_shadow_r;
  logic [N_amisha:0]   cmp_active_r;
  logic                cmp_ready_r;
  logic                pwm_raw_r;
  logic                period_tick_r;
  logic                boundary_s;
  logic                load_shadow_s;
  logic                swap_s;

  // Period boundary: clear, or the counter wrapping in its current direction.
  always_comb begin
    boundary_s = cnt_clr_amisha
               | (cnt_en_amisha &  cnt_up_amisha & max_tick_amisha)
               | (cnt_en_amisha & ~cnt_up_amisha & min_tick_amisha);
  end

  // Handshake FSM next state: accept in IDLE, apply the pending value on a boundary.
  always_comb begin
    state_next_s  = state_r;
    load_shadow_s = 1'b0;
    swap_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmp_valid_amisha) begin
          load_shadow_s = 1'b1;
          state_next_s  = PEND;
        end else begin
          state_next_s  = IDLE;
        end
      end
      PEND: begin
        if (boundary_s) begin
          swap_s       = 1'b1;
          state_next_s = IDLE;
        end else begin
          state_next_s = PEND;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, compare buffers and registered outputs. The comparison uses the
  // old active value on the swap cycle, so the new value starts the next period.
  always_ff @(posedge clk_amisha) begin
    if (!reset_n_amisha) begin
      state_r       <= IDLE;
      cmp_shadow_r  <= '0;
      cmp_active_r  <= '0;
      cmp_ready_r   <= 1'b1;
      pwm_raw_r     <= 1'b0;
      period_tick_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cmp_ready_r <= (state_next_s == IDLE);
      if (load_shadow_s) begin
        cmp_shadow_r <= clamp_cmp(cmp_data_amisha);
      end else begin
        cmp_shadow_r <= cmp_shadow_r;
      end
      if (swap_s) begin
        cmp_active_r <= cmp_shadow_r;
      end else begin
        cmp_active_r <= cmp_active_r;
      end
      pwm_raw_r     <= ({1'b0, q_amisha} < cmp_active_r);
      period_tick_r <= boundary_s;
    end
  end

  assign cmp_ready_amisha   = cmp_ready_r;
  assign period_tick_amisha = period_tick_r;

`ifdef PWM_COMPL_EN
  deadtime_gen_amisha #(
    .DEADTIME_amisha (DEADTIME_amisha)
  ) u_deadtime (
    .clk_amisha     (clk_amisha),
    .reset_n_amisha (reset_n_amisha),
    .pwm_raw_amisha (pwm_raw_r),
    .pwm_amisha     (pwm_amisha),
    .pwm_n_amisha   (pwm_n_amisha)
  );
`else
  localparam int unused_deadtime_s = DEADTIME_amisha;
  assign pwm_amisha = pwm_raw_r;
`endif

endmodule

// File: tb/tb_pwm_compare_amisha.sv
// Directed bench for pwm_compare_amisha with N=4. The bench models the
// upstream counter itself and checks hand-computed duty counts per period.
module tb_pwm_compare_amisha;

  localparam int N  = 4;
  localparam int DT = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] q;
  logic         max_tick;
  logic         min_tick;
  logic         en;
  logic         up;
  logic         clr;
  logic         valid;
  logic [N:0]   data;
  logic         ready;
  logic         pwm;
  logic         ptick;
`ifdef PWM_COMPL_EN
  logic         pwm_n;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pwm_compare_amisha #(
    .N_amisha        (N),
    .DEADTIME_amisha (DT)
  ) dut (
    .clk_amisha         (clk),
    .reset_n_amisha     (reset_n),
    .q_amisha           (q),
    .max_tick_amisha    (max_tick),
    .min_tick_amisha    (min_tick),
    .cnt_en_amisha      (en),
    .cnt_up_amisha      (up),
    .cnt_clr_amisha     (clr),
    .cmp_valid_amisha   (valid),
    .cmp_data_amisha    (data),
    .cmp_ready_amisha   (ready),
    .pwm_amisha         (pwm),
`ifdef PWM_COMPL_EN
    .pwm_n_amisha       (pwm_n),
`endif
    .period_tick_amisha (ptick)
  );

  // One clock: the modelled counter steps with the controls in force before the edge.
  task automatic tick();
    logic [N-1:0] qn;
    qn = clr ? '0 : (en ? (up ? q + N'(1) : q - N'(1)) : q);
    @(posedge clk);
    #1;
    q        = qn;
    max_tick = (q == {N{1'b1}});
    min_tick = (q == '0);
  endtask

  task automatic offer(input logic [N:0] d);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
  endtask

  task automatic wait_period(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ptick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_period(output int highs, output int ticks, output logic last);
    highs = 0;
    ticks = 0;
    last  = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (pwm === 1'b1) highs++;
      if (ptick === 1'b1) ticks++;
      if (k == 16) last = ptick;
    end
  endtask

  task automatic test_reset();
    int highs;
    reset_n = 1'b0; valid = 1'b1; data = 5'd7; en = 1'b0; up = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    tick();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
    checks++; if (pwm !== 1'b0) begin errors++; $display("FAIL reset_pwm got=%b exp=0", pwm); end
    checks++; if (ptick !== 1'b0) begin errors++; $display("FAIL reset_ptick got=%b exp=0", ptick); end
    reset_n = 1'b1; valid = 1'b0; en = 1'b1;
    highs = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (pwm === 1'b1) highs++;
    end
    en = 1'b0;
    checks++; if (highs !== 0) begin errors++; $display("FAIL reset_no_accept highs got=%0d exp=0", highs); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_idle_ready got=%b exp=1", ready); end
  endtask

  task automatic test_basic_duty();
    bit ok; int highs; int ticks; logic last;
    offer(5'd5);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL duty_ready_low got=%b exp=0", ready); end
    en = 1'b1; up = 1'b1;
    wait_period(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL duty_boundary timeout got=%b exp=1", ok); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL duty_ready_back got=%b exp=1", ready); end
    for (int p = 0; p < 2; p++) begin
      run_period(highs, ticks, last);
      checks++; if (highs !== 5) begin errors++; $display("FAIL duty_highs got=%0d exp=5", highs); end
      checks++; if (ticks !== 1 || last !== 1'b1) begin errors++; $display("FAIL duty_ptick got=%0d/%b exp=1/1", ticks, last); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int highs; int ticks; logic last;
    for (int i = 0; i < 4; i++) tick();
    valid = 1'b1; data = 5'd3;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept3 ready got=%b exp=0", ready); end
    data = 5'd9;
    tick();
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_hold9 ready got=%b exp=0", ready); end
    wait_period(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_boundary timeout got=%b exp=1", ok); end
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_back got=%b exp=1", ready); end
    highs = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 1) begin
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_accept9 ready got=%b exp=0", ready); end
        valid = 1'b0;
      end
      if (pwm === 1'b1) highs++;
    end
    checks++; if (highs !== 3) begin errors++; $display("FAIL b2b_duty3 got=%0d exp=3", highs); end
    run_period(highs, ticks, last);
    checks++; if (highs !== 9) begin errors++; $display("FAIL b2b_duty9 got=%0d exp=9", highs); end
  endtask

  task automatic test_extremes();
    bit ok; int highs; int ticks; logic last;
    logic [N:0] vals [3];
    int         expv [3];
    vals[0] = 5'd0;  expv[0] = 0;
    vals[1] = 5'd16; expv[1] = 16;
    vals[2] = 5'd31; expv[2] = 16;
    for (int v = 0; v < 3; v++) begin
      offer(vals[v]);
      wait_period(ok);
      checks++; if (ok !== 1'b1) begin errors++; $display("FAIL extreme_boundary[%0d] timeout", v); end
      run_period(highs, ticks, last);
      checks++; if (highs !== expv[v]) begin errors++; $display("FAIL extreme_duty cmp=%0d got=%0d exp=%0d", vals[v], highs, expv[v]); end
    end
  endtask

  task automatic test_down_clear();
    bit ok; int highs; int ticks; logic last;
    up = 1'b0;
    offer(5'd4);
    checks++; if (ptick !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL down_same_cycle ptick/ready got=%b/%b exp=1/0", ptick, ready); end
    wait_period(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL down_boundary timeout got=%b exp=1", ok); end
    run_period(highs, ticks, last);
    checks++; if (highs !== 4) begin errors++; $display("FAIL down_duty got=%0d exp=4", highs); end
    checks++; if (ticks !== 1 || last !== 1'b1) begin errors++; $display("FAIL down_ptick got=%0d/%b exp=1/1", ticks, last); end
    for (int i = 0; i < 3; i++) tick();
    offer(5'd12);
    tick(); tick();
    checks++; if (ptick !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL clr_pending ptick/ready got=%b/%b exp=0/0", ptick, ready); end
    clr = 1'b1;
    tick();
    clr = 1'b0; up = 1'b1;
    checks++; if (ptick !== 1'b1 || ready !== 1'b1) begin errors++; $display("FAIL clr_swap ptick/ready got=%b/%b exp=1/1", ptick, ready); end
    run_period(highs, ticks, last);
    checks++; if (highs !== 12) begin errors++; $display("FAIL clr_duty got=%0d exp=12", highs); end
  endtask

  task automatic test_hold();
    bit ok; int highs; int ticks; logic last;
    en = 1'b0;
    offer(5'd2);
    highs = 0; ticks = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pwm === 1'b1) highs++;
      if (ptick === 1'b1) ticks++;
    end
    checks++; if (ticks !== 0 || highs !== 20) begin errors++; $display("FAIL hold_static ticks/highs got=%0d/%0d exp=0/20", ticks, highs); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL hold_pending ready got=%b exp=0", ready); end
    en = 1'b1; up = 1'b1;
    wait_period(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL hold_boundary timeout got=%b exp=1", ok); end
    run_period(highs, ticks, last);
    checks++; if (highs !== 2) begin errors++; $display("FAIL hold_duty got=%0d exp=2", highs); end
  endtask

`ifdef PWM_COMPL_EN
  task automatic test_compl();
    bit ok; int overlap; int run; int runs_bad; int runs;
    en = 1'b0;
    offer(5'd8);
    en = 1'b1; up = 1'b1;
    wait_period(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL compl_boundary timeout got=%b exp=1", ok); end
    overlap = 0; run = 0; runs_bad = 0; runs = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      if ((pwm & pwm_n) === 1'b1) overlap++;
      if (pwm === 1'b0 && pwm_n === 1'b0) begin
        run++;
      end else if (run > 0) begin
        runs++;
        if (run != DT) runs_bad++;
        run = 0;
      end
    end
    checks++; if (overlap !== 0) begin errors++; $display("FAIL compl_overlap got=%0d exp=0", overlap); end
    checks++; if (runs_bad !== 0 || runs < 4) begin errors++; $display("FAIL compl_deadtime bad=%0d runs=%0d exp=0/>=4", runs_bad, runs); end
  endtask
`endif

  initial begin
    reset_n = 1'b0; q = '0; max_tick = 1'b0; min_tick = 1'b1;
    en = 1'b0; up = 1'b1; clr = 1'b0; valid = 1'b0; data = '0;
    test_reset();
`ifdef PWM_COMPL_EN
    test_compl();
`else
    test_basic_duty();
    test_back_to_back();
    test_extremes();
    test_down_clear();
    test_hold();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
